// File: rtl/passcode_entry.sv
// passcode_entry: collects BCD digit strobes from the keypad decoder and packs
// DIGITS of them into one code, first digit in the top nibble. A finished code
// is latched on _Data_Out and announced with a LOAD_CYCLES-long load strobe.
// Partial entries are dropped on _Key_Clear or after TIMEOUT_CYCLES idle cycles.
module passcode_entry #(
  parameter int DIGITS         = 4,
  parameter int LOAD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            _Key_In,
  input  logic                  _Key_Valid,
  input  logic                  _Key_Clear,
  output logic [4*DIGITS-1:0]   _Data_Out,
  output logic                  _Data_Out_Load,
  output logic [2:0]            _Digit_Count,
  output logic                  _Busy
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int LW = $clog2(LOAD_CYCLES + 1);

  localparam logic [2:0]    LAST_DIGIT = 3'(DIGITS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    LOAD    = 2'd2
  } state_t;

  state_t        state_q;
  // Only the first DIGITS-1 digits need storing; the last one goes straight
  // into the latched code.
  logic [W-5:0]  sr_q;
  logic [W-1:0]  data_q;
  logic          load_q;
  logic          busy_q;
  logic [2:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic [LW-1:0] lcnt_q;

  logic          key_ok;
  logic [W-1:0]  code_d;

  // A key counts only when it is a decimal digit; A-F are treated as no key.
  assign key_ok = _Key_Valid && (_Key_In <= 4'd9);
  assign code_d = {sr_q, _Key_In};

  // Entry FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      load_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      lcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          if (_Key_Clear) begin
            // Clear beats a same-cycle key.
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
          end else if (key_ok) begin
            tmo_q <= '0;
            if (cnt_q == LAST_DIGIT) begin
              state_q <= LOAD;
              data_q  <= code_d;
              load_q  <= 1'b1;
              busy_q  <= 1'b1;
              sr_q    <= '0;
              cnt_q   <= '0;
              lcnt_q  <= '0;
            end else begin
              state_q <= COLLECT;
              sr_q    <= code_d[W-5:0];
              cnt_q   <= cnt_q + 3'd1;
            end
          end else if (state_q == COLLECT) begin
            // Inactivity: a key in the same cycle already took the branch above.
            if (tmo_q == TMO_LAST) begin
              state_q <= IDLE;
              sr_q    <= '0;
              cnt_q   <= '0;
              tmo_q   <= '0;
            end else begin
              tmo_q <= tmo_q + 1'b1;
            end
          end
        end
        LOAD: begin
          // Keys and clears are dropped while the strobe is up.
          if (lcnt_q == LOAD_LAST) begin
            state_q <= IDLE;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
            lcnt_q  <= '0;
          end else begin
            lcnt_q <= lcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          sr_q    <= '0;
          load_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          tmo_q   <= '0;
          lcnt_q  <= '0;
        end
      endcase
    end
  end

  assign _Data_Out      = data_q;
  assign _Data_Out_Load = load_q;
  assign _Digit_Count   = cnt_q;
  assign _Busy          = busy_q;

endmodule

// File: tb/tb_passcode_entry.sv
// tb_passcode_entry: directed test-plan sequences followed by random key
// traffic, every cycle compared against a queue-based model of the entry rules.
module tb_passcode_entry;

  localparam int DIGITS = 4;
  localparam int LC     = 2;
  localparam int TO     = 8;
  localparam int W      = 4 * DIGITS;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   ki  = '0;
  logic         kv  = 1'b0;
  logic         kc  = 1'b0;
  logic [W-1:0] dout;
  logic         dload;
  logic [2:0]   dcnt;
  logic         dbusy;

  int n_tests = 0;
  int n_fail  = 0;

  // model: digits entered so far, cycles of strobe left, idle cycles since last digit
  int           q[$];
  int           load_rem = 0;
  int           idle_cnt = 0;
  logic [W-1:0] m_data   = '0;

  passcode_entry #(.DIGITS(DIGITS), .LOAD_CYCLES(LC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), ._Key_In(ki), ._Key_Valid(kv), ._Key_Clear(kc),
    ._Data_Out(dout), ._Data_Out_Load(dload), ._Digit_Count(dcnt), ._Busy(dbusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Apply one clock edge of the entry rules to the model.
  task automatic model_step();
    logic [W-1:0] code;
    if (rst) begin
      q.delete(); load_rem = 0; idle_cnt = 0; m_data = '0;
    end else if (load_rem > 0) begin
      load_rem--;
    end else if (kc) begin
      q.delete(); idle_cnt = 0;
    end else if (kv && ki <= 4'd9) begin
      q.push_back(int'(ki));
      idle_cnt = 0;
      if (q.size() == DIGITS) begin
        code = '0;
        foreach (q[i]) code = code * 16 + W'(q[i]);
        m_data = code;
        q.delete();
        load_rem = LC;
      end
    end else if (q.size() > 0) begin
      idle_cnt++;
      if (idle_cnt == TO) begin
        q.delete(); idle_cnt = 0;
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic c, input logic [3:0] k);
    rst = r; kv = v; kc = c; ki = k;
    @(posedge clk);
    model_step();
    #1;
    chk("data",  32'(dout),  32'(m_data));
    chk("load",  32'(dload), 32'(load_rem > 0));
    chk("busy",  32'(dbusy), 32'(load_rem > 0));
    chk("count", 32'(dcnt),  32'(q.size()));
  endtask

  task automatic key(input logic [3:0] k);
    step(1'b0, 1'b1, 1'b0, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  initial begin
    int ld_seen;
    step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst_data", 32'(dout), 32'h0);
    chk("rst_load", 32'(dload), 32'h0);
    chk("rst_cnt", 32'(dcnt), 32'h0);

    // 1,4,7,6 -> 1476, strobe exactly two cycles, count 1,2,3,0
    key(4'd1); chk("cnt1", 32'(dcnt), 32'd1);
    key(4'd4); chk("cnt2", 32'(dcnt), 32'd2);
    key(4'd7); chk("cnt3", 32'(dcnt), 32'd3);
    key(4'd6); chk("cnt4", 32'(dcnt), 32'd0);
    chk("code1476", 32'(dout), 32'h1476);
    chk("ld_c1", 32'(dload), 32'd1);
    idle(1); chk("ld_c2", 32'(dload), 32'd1);
    idle(1); chk("ld_c3", 32'(dload), 32'd0);
    idle(2);

    // partial entry cleared, then 2456; no strobe for the partial
    ld_seen = 0;
    key(4'd2); ld_seen += int'(dload);
    key(4'd4); ld_seen += int'(dload);
    step(1'b0, 1'b0, 1'b1, 4'd0); ld_seen += int'(dload);
    chk("clr_cnt", 32'(dcnt), 32'd0);
    key(4'd2); ld_seen += int'(dload);
    key(4'd4); ld_seen += int'(dload);
    key(4'd5); ld_seen += int'(dload);
    chk("no_partial_ld", 32'(ld_seen), 32'd0);
    key(4'd6);
    chk("code2456", 32'(dout), 32'h2456);
    idle(3);

    // 0xB ignored; 9 pressed during strobe dropped
    key(4'd1); key(4'd4); key(4'hB);
    chk("cnt_b", 32'(dcnt), 32'd2);
    key(4'd7); key(4'd6);
    chk("code1476b", 32'(dout), 32'h1476);
    key(4'd9);
    idle(2);
    chk("cnt_after_ld", 32'(dcnt), 32'd0);
    idle(1);

    // inactivity timeout
    key(4'd3);
    idle(TO - 1);
    chk("tmo_pre", 32'(dcnt), 32'd1);
    idle(1);
    chk("tmo_cnt", 32'(dcnt), 32'd0);
    key(4'd1); key(4'd4); key(4'd7); key(4'd6);
    chk("code1476c", 32'(dout), 32'h1476);
    idle(3);

    // key and clear together; then reset during strobe
    key(4'd1); key(4'd2);
    step(1'b0, 1'b1, 1'b1, 4'd5);
    chk("kc_cnt", 32'(dcnt), 32'd0);
    key(4'd3); key(4'd4); key(4'd5); key(4'd6);
    chk("code3456", 32'(dout), 32'h3456);
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst_ld_load", 32'(dload), 32'd0);
    chk("rst_ld_data", 32'(dout), 32'd0);
    idle(2);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      logic r, v, c;
      r = ($urandom_range(0, 299) == 0);
      v = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 24) == 0);
      step(r, v, c, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 59) == 0) idle($urandom_range(TO - 2, TO + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
